pipe_rr_arbiter: RTL
====================

Name: pipe_rr_arbiter

Overview:
- Shares one downstream fixed-latency stream resource (a dreg pipe chain) among NUM dti requesters.
- Uses a round-robin grant and credit-based admission control.
- Each accepted word is tagged with its requester index and held in a single registered output slot (dreg-like) before entering the pipe.
- A per-transaction ack from the pipe's far end returns credits, bounding in-flight words to MAX_OUTSTANDING.

Parameters:
- NUM, 4: number of requesters, ≥2.
- DIN, 16: payload width per requester.
- MAX_OUTSTANDING, 2: max words accepted but not yet acked. Includes the output slot. Range 1..255.
- W_IDX, $clog2(NUM): derived tag width. Not overridable.
- W_CNT, $clog2(MAX_OUTSTANDING+1): derived credit counter width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- din_data, input, NUM*DIN: requester payloads; requester i occupies bits [i*DIN +: DIN].
- din_valid, input, NUM: per-requester valid.
- din_ready, output, NUM: per-requester ready; at most one bit high per cycle.
- dout, dti.producer, W_IDX+DIN: tagged word to the pipe; data = {idx, payload}, idx in MSBs.
- ack, input, 1: one-cycle pulse per word retired at the pipe output.
- outstanding, output, W_CNT: current credit-counter value.

Behaviour:
- Reset:
  - dout.valid=0, dout.data=0.
  - RR pointer ptr=0, counter cnt=0, outstanding=0.
  - din_ready=0 during the reset cycle.
- Slot free: slot_free = !dout.valid || dout.ready.
- Credit:
  - credit_ok = (cnt < MAX_OUTSTANDING) || ack. A same-cycle ack frees a credit.
- Grant: combinational.
  - First i with din_valid[i], searching ptr, ptr+1, …, NUM-1, 0, …, ptr-1.
  - Only when slot_free && credit_ok.
  - din_ready[g]=1 for the granted index only; all others 0.
  - din_ready never depends on other requesters' ready, and never depends on dout.valid except through slot_free.
- Accept (din_valid[g] && din_ready[g]), next edge:
  - dout.data={g, payload_g}, dout.valid=1.
  - ptr=(g+1) mod NUM.
- No accept and dout.ready:
  - dout.valid=0; data holds its previous value.
  - ptr unchanged.
- Latency: 1 cycle from input handshake to dout.valid. Throughput: 1 word/cycle when credits allow.
- dout.valid && !dout.ready: data and valid stable until the handshake (dti rule).
- Counter update, per cycle:
  - cnt += accept − ack.
  - accept && ack → cnt unchanged.
  - ack with cnt==0 → ignored, cnt stays 0; a sim-only assertion fires.
  - cnt never exceeds MAX_OUTSTANDING; covered by an assertion.
- outstanding = cnt, registered.
- Fairness:
  - A continuously valid requester is granted within NUM grants.
  - ptr wraps NUM-1 → 0.
- Reset mid-operation:
  - All state returns to reset values next edge.
  - The in-flight word in the slot is dropped.
  - Acks arriving after reset for pre-reset words fall under the cnt==0 rule; the integrator resets the pipe together with this block.
- NUM not a power of 2: tag values ≥NUM never produced.

Decomposition:
- Package pipe_arb_pkg: function for next RR pointer with wrap; localparam helpers for W_IDX and W_CNT.
- Sub-module rr_pick (purely combinational):
  - Inputs: req[NUM], ptr[W_IDX], en.
  - Outputs: gnt onehot[NUM], gnt_idx[W_IDX], gnt_vld.
  - Reused by future multi-resource schedulers.
- Top module holds ptr, the output slot, and the credit counter.

Test Plan:
1. Reset then single requester: din_valid=4'b0100, data 0x00AB, dout.ready=1 → din_ready=4'b0100; next cycle dout.data={2'd2,16'h00AB}, valid=1; outstanding=1.
2. All requesters always valid, MAX_OUTSTANDING=4, ack 4 cycles after each grant, ready=1 → grant order 0,1,2,3,0,…; no gaps once steady; outstanding never >4.
3. Credit exhaustion: MAX_OUTSTANDING=2, no ack → two accepts then din_ready=0 forever. Pulse ack once → exactly one more accept on that same cycle; cnt stays 2.
4. Backpressure: dout.ready=0 for 5 cycles with a word in the slot → dout.data/valid stable; din_ready=0 throughout. Ready rises → the next grant lands in the same cycle as the drain.
5. Simultaneous accept+ack at cnt=2 (max) → accept occurs, cnt stays 2. Spurious ack at cnt=0 → cnt=0 and the assertion fires.
6. Sync reset asserted while dout.valid=1 and cnt=2 → next cycle dout.valid=0, outstanding=0, ptr=0; requester 0 wins the first post-reset grant.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared helpers for the round-robin pipe arbiter: derived widths and pointer wrap.
package pipe_arb_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    // Successor of p in a ring of n requesters.
    function automatic int rr_next(input int p, input int n);
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/pipe_rr_arbiter_if.sv
// Valid/ready stream carrying one tagged word per handshake.
interface dti_if #(parameter int W = 18);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/pipe_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM   = 4,
    parameter int W_IDX = 2
) (
    input  logic [NUM-1:0]   req,
    input  logic [W_IDX-1:0] ptr,
    input  logic             en,
    output logic [NUM-1:0]   gnt,
    output logic [W_IDX-1:0] gnt_idx,
    output logic             gnt_vld
);
    localparam logic [W_IDX:0] NUM_L = (W_IDX + 1)'(NUM);

    always_comb begin
        logic [W_IDX:0]   s;
        logic [W_IDX-1:0] j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        s       = '0;
        j       = '0;
        for (int k = 0; k < NUM; k++) begin
            s = {1'b0, ptr} + (W_IDX + 1)'(k);
            if (s >= NUM_L) s = s - NUM_L;
            j = s[W_IDX-1:0];
            if (en && !gnt_vld && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = j;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding a fixed-latency pipe through one registered slot,
// with a credit counter that caps words accepted but not yet acked.
module pipe_rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int NUM             = 4,
    parameter int DIN             = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM*DIN-1:0]                din_data,
    input  logic [NUM-1:0]                    din_valid,
    output logic [NUM-1:0]                    din_ready,
    dti_if.producer                           dout,
    input  logic                              ack,
    output logic [cnt_w(MAX_OUTSTANDING)-1:0] outstanding
);
    localparam int W_IDX = idx_w(NUM);
    localparam int W_CNT = cnt_w(MAX_OUTSTANDING);
    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(MAX_OUTSTANDING);

    logic [W_IDX-1:0]        ptr_q, ptr_d;
    logic [W_CNT-1:0]        cnt_q, cnt_d;
    logic [W_IDX+DIN-1:0]    data_q, data_d;
    logic                    valid_q, valid_d;
    logic [NUM-1:0][DIN-1:0] lane;
    logic                    slot_free, credit_ok, ack_eff;
    logic [W_IDX-1:0]        gnt_idx;
    logic                    accept;

    assign lane      = din_data;
    assign slot_free = !valid_q || dout.ready;
    // A same-cycle ack frees a credit for the word being accepted now.
    assign credit_ok = (cnt_q < CNT_MAX) || ack;
    assign ack_eff   = ack && (cnt_q != '0);

    rr_pick #(.NUM(NUM), .W_IDX(W_IDX)) u_pick (
        .req     (din_valid),
        .ptr     (ptr_q),
        .en      (slot_free && credit_ok && !rst),
        .gnt     (din_ready),
        .gnt_idx (gnt_idx),
        .gnt_vld (accept)
    );

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (accept) begin
            data_d  = {gnt_idx, lane[gnt_idx]};
            valid_d = 1'b1;
            ptr_d   = W_IDX'(rr_next(int'(gnt_idx), NUM));
        end else if (dout.ready) begin
            valid_d = 1'b0;
        end
        unique case ({accept, ack_eff})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dout.valid  = valid_q;
    assign dout.data   = data_q;
    assign outstanding = cnt_q;

    // A stray ack is dropped; warn so the integration bug is visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ack && cnt_q == '0))
                else $warning("pipe_rr_arbiter: ack with nothing outstanding ignored");
            assert (cnt_q <= CNT_MAX)
                else $error("pipe_rr_arbiter: credit counter above limit");
        end
    end

endmodule
